toy_sa_seq: RTL
===============

// Module: toy_sa_seq
// PURPOSE
//  Sequencer for the systolic-array matrix core (toy_mcore), driven by the vector core.
//  Accepts one matrix-multiply command and runs it in three phases:
//   - weight load: N rows from vs1..
//   - skewed operand streaming: N rows from vs2..
//   - result collection: N rows written to vd..
//  Drives the per-row load/shift enables, VRF read indices and VRF write-back indices.
//  One command in flight at a time.
// PARAMETERS
//  N      = V_ELEMENT_NUM   (8)  array dimension: rows, columns and elements per vreg
//  IDX_W  = V_REG_IDX_WIDTH (5)  vector register index width
//  OPC_W  = V_OPC_WIDTH     (8)  opcode width
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-high
//  cmd_vld      in   1      command valid
//  cmd_rdy      out  1      command ready; high only in IDLE
//  cmd_opcode   in   OPC_W  opcode; only OPC_MMUL is legal
//  cmd_vs1      in   IDX_W  first weight vreg
//  cmd_vs2      in   IDX_W  first operand vreg
//  cmd_vd       in   IDX_W  first destination vreg
//  vrf_rd_en    out  1      VRF read strobe
//  vrf_rd_idx   out  IDX_W  VRF read index
//  sa_load_en   out  N      per-row weight-load enable
//  sa_shift_en  out  N      per-row shift enable
//  sa_res_en    in   N      per-row result valid from the array
//  vrf_wr_en    out  1      write-back strobe
//  vrf_wr_idx   out  IDX_W  write-back index
//  busy         out  1      high in any state other than IDLE
//  done         out  1      one-cycle pulse when a command completes
//  err          out  1      one-cycle pulse on a protocol error
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0 while rst=1, including cmd_rdy; cmd_rdy=1 on the first cycle after reset.
//  - Accept: cmd_vld&cmd_rdy in cycle C latches vs1/vs2/vd.
//    - OPC_MMUL: state=LOAD in C+1.
//    - Any other opcode: err=1 in C+1, stays IDLE, command dropped.
//  - LOAD: k = 0..N-1, one cycle each.
//    - vrf_rd_en=1, vrf_rd_idx=vs1+k (mod 2^IDX_W).
//    - sa_load_en one-hot at bit k.
//    - After k=N-1, go to STREAM.
//  - STREAM: t = 0..2N-2.
//    - vrf_rd_en=1 and vrf_rd_idx=vs2+t only for t<N.
//    - sa_shift_en[i]=1 iff i<=t<=i+N-1 (diagonal skew).
//    - After t=2N-2, go to DRAIN.
//  - Write-back, in STREAM and DRAIN: each cycle with |sa_res_en writes one row.
//    - vrf_wr_en=1 in the same cycle (combinational from sa_res_en).
//    - vrf_wr_idx=vd+w (mod 2^IDX_W), then w++.
//    - More than one bit set in one cycle: write only the lowest row this cycle and pulse err.
//      Remaining rows are not buffered.
//  - DRAIN: wait until w==N, then go to DONE.
//    - Watchdog: 4N cycles spent in DRAIN without reaching w==N -> err pulse, go to IDLE, no done.
//  - DONE: one cycle, done=1, busy=0, then IDLE.
//    - cmd_rdy is 0 in DONE; earliest next accept is DONE+1.
//  - Nominal timing: accept C, LOAD C+1..C+N, STREAM C+N+1..C+3N-1, DONE at the cycle after the Nth write.
//  - Corner cases:
//    - sa_res_en in IDLE/LOAD/DONE: ignored, err pulse.
//    - Write-back index wraps modulo 2^IDX_W.
//    - rst asserted mid-command: abort immediately, all enables 0 next cycle, no done.
//    - cmd_vld while busy: not accepted; cmd_rdy stays 0.
// STRUCTURE
//  - toy_vpack holds:
//    - OPC_MMUL
//    - seq state enum typedef sa_seq_state_t {IDLE, LOAD, STREAM, DRAIN, DONE}
//    - watchdog constant SA_DRAIN_TMO = 4*V_ELEMENT_NUM
//  - One sub-module, toy_sa_skew_gen: combinational t -> sa_shift_en[N] diagonal mask generator.
//  - Counters: k/t share one phase counter of width $clog2(2N); w and watchdog are separate.
// TESTING (N=4, IDX_W=5)
//  1. MMUL vs1=0, vs2=8, vd=16; array returns one res row per cycle starting STREAM t=4
//     -> rd_idx 0,1,2,3 then 8,9,10,11.
//     -> shift_en 0001,0011,0111,1111,1110,1100,1000.
//     -> writes 16..19, done at the cycle after the 4th write.
//  2. vs1=30, vd=31 -> rd_idx 30,31,0,1; wr_idx 31,0,1,2 (wrap).
//  3. opcode!=OPC_MMUL -> err pulse at C+1, busy stays 0, cmd_rdy stays 1.
//  4. Only 3 res rows returned -> err 16 cycles after DRAIN entry, IDLE, no done.
//  5. sa_res_en=0101 in one cycle -> single write of row 0, err pulse, w+=1.
//  6. rst during STREAM t=2 -> next cycle all enables 0, busy=0.
//     -> cmd_rdy=1 after release; new command completes normally.
//     -> Back-to-back: 2nd cmd_vld held through 1st -> accepted at DONE+1.

Source files
------------

// File: rtl/toy_vpack.sv
// Shared constants and types for the vector-core / systolic-array sequencer.
package toy_vpack;
  localparam int V_ELEMENT_NUM   = 8;
  localparam int V_REG_IDX_WIDTH = 5;
  localparam int V_OPC_WIDTH     = 8;

  localparam logic [V_OPC_WIDTH-1:0] OPC_MMUL = 8'h40;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} sa_seq_state_t;

  function automatic int sa_drain_tmo(int n);
    return 4 * n;
  endfunction

  localparam int SA_DRAIN_TMO = sa_drain_tmo(V_ELEMENT_NUM);
endpackage

// File: rtl/toy_sa_seq_if.sv
// Command / VRF / array handshake bundle between the vector core and the SA sequencer.
interface toy_sa_seq_if
  import toy_vpack::*;
#(
  parameter int N     = V_ELEMENT_NUM,
  parameter int IDX_W = V_REG_IDX_WIDTH,
  parameter int OPC_W = V_OPC_WIDTH
);
  logic             cmd_vld;
  logic             cmd_rdy;
  logic [OPC_W-1:0] cmd_opcode;
  logic [IDX_W-1:0] cmd_vs1;
  logic [IDX_W-1:0] cmd_vs2;
  logic [IDX_W-1:0] cmd_vd;
  logic             vrf_rd_en;
  logic [IDX_W-1:0] vrf_rd_idx;
  logic [N-1:0]     sa_load_en;
  logic [N-1:0]     sa_shift_en;
  logic [N-1:0]     sa_res_en;
  logic             vrf_wr_en;
  logic [IDX_W-1:0] vrf_wr_idx;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_vld, cmd_opcode, cmd_vs1, cmd_vs2, cmd_vd, sa_res_en,
    input  cmd_rdy, vrf_rd_en, vrf_rd_idx, sa_load_en, sa_shift_en,
           vrf_wr_en, vrf_wr_idx, busy, done, err
  );

  modport slave (
    input  cmd_vld, cmd_opcode, cmd_vs1, cmd_vs2, cmd_vd, sa_res_en,
    output cmd_rdy, vrf_rd_en, vrf_rd_idx, sa_load_en, sa_shift_en,
           vrf_wr_en, vrf_wr_idx, busy, done, err
  );
endinterface

// File: rtl/toy_sa_skew_gen.sv
// Diagonal skew mask: row i shifts while streaming step t lies in [i, i+N-1].
module toy_sa_skew_gen #(
  parameter int N   = 8,
  parameter int T_W = $clog2(2*N)
) (
  input  logic [T_W-1:0] t,
  output logic [N-1:0]   mask
);
  localparam logic [T_W-1:0] WIN = T_W'(N);

  for (genvar i = 0; i < N; i++) begin : g_row
    localparam logic [T_W-1:0] LO = T_W'(i);
    logic [T_W-1:0] d;
    // t < i wraps to >= 2^T_W - i > N, so one unsigned compare covers both bounds
    assign d       = t - LO;
    assign mask[i] = d < WIN;
  end
endmodule

// File: rtl/toy_sa_seq.sv
// Systolic-array sequencer: weight load, skewed operand stream, result write-back.
module toy_sa_seq
  import toy_vpack::*;
#(
  parameter int N     = V_ELEMENT_NUM,
  parameter int IDX_W = V_REG_IDX_WIDTH,
  parameter int OPC_W = V_OPC_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  toy_sa_seq_if.slave sif
);
  localparam int PH_W = $clog2(2*N);
  localparam int W_W  = $clog2(N) + 2;
  localparam int TMO  = sa_drain_tmo(N);
  localparam int WD_W = $clog2(TMO) + 1;

  localparam logic [PH_W-1:0]  K_LAST  = PH_W'(N-1);
  localparam logic [PH_W-1:0]  T_LAST  = PH_W'(2*N-2);
  localparam logic [PH_W-1:0]  T_RD    = PH_W'(N);
  localparam logic [W_W-1:0]   W_END   = W_W'(N);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TMO-1);
  localparam logic [OPC_W-1:0] OPC_MM  = OPC_W'(OPC_MMUL);

  sa_seq_state_t    state, state_nxt;
  logic [PH_W-1:0]  ph;
  logic [W_W-1:0]   w, w_nxt;
  logic [WD_W-1:0]  wd;
  logic [IDX_W-1:0] vs1_q, vs2_q, vd_q;
  logic             err_q, err_set, err_c;
  logic             accept, in_wb, res_any, res_multi, wr_ok;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [N-1:0]     load_en, shift_en, skew;

  toy_sa_skew_gen #(.N(N), .T_W(PH_W)) u_skew (.t(ph), .mask(skew));

  assign accept    = sif.cmd_vld && (state == IDLE);
  assign in_wb     = (state == STREAM) || (state == DRAIN);
  assign res_any   = |sif.sa_res_en;
  assign res_multi = (sif.sa_res_en & (sif.sa_res_en - N'(1))) != '0;
  // Multi-row cycles still write exactly one row; the rest are lost and flagged.
  assign wr_ok     = in_wb && res_any;
  assign w_nxt     = w + W_W'(wr_ok);
  assign err_c     = (res_any && !in_wb) || (wr_ok && res_multi);

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = '0;
    load_en   = '0;
    shift_en  = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (sif.cmd_opcode == OPC_MM) state_nxt = LOAD;
          else                          err_set   = 1'b1;
        end
      end
      LOAD: begin
        rd_en   = 1'b1;
        rd_idx  = vs1_q + IDX_W'(ph);
        load_en = N'(1) << ph;
        if (ph == K_LAST) state_nxt = STREAM;
      end
      STREAM: begin
        rd_en    = ph < T_RD;
        rd_idx   = rd_en ? vs2_q + IDX_W'(ph) : '0;
        shift_en = skew;
        if (ph == T_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_nxt >= W_END) begin
          state_nxt = DONE;
        end else if (wd == WD_LAST) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph    <= '0;
      w     <= '0;
      wd    <= '0;
      err_q <= 1'b0;
      vs1_q <= '0;
      vs2_q <= '0;
      vd_q  <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_set;
      if (accept) begin
        vs1_q <= sif.cmd_vs1;
        vs2_q <= sif.cmd_vs2;
        vd_q  <= sif.cmd_vd;
      end
      // k and t share this counter; it restarts on every phase change
      if (state_nxt != state || !(state inside {LOAD, STREAM})) ph <= '0;
      else                                                      ph <= ph + 1'b1;
      w  <= (state == IDLE)  ? '0 : w_nxt;
      wd <= (state == DRAIN) ? wd + 1'b1 : '0;
    end
  end

  // Everything is forced low while reset is held, ahead of the state register.
  assign sif.cmd_rdy     = !rst && (state == IDLE);
  assign sif.vrf_rd_en   = !rst && rd_en;
  assign sif.vrf_rd_idx  = rst ? '0 : rd_idx;
  assign sif.sa_load_en  = rst ? '0 : load_en;
  assign sif.sa_shift_en = rst ? '0 : shift_en;
  assign sif.vrf_wr_en   = !rst && wr_ok;
  assign sif.vrf_wr_idx  = (rst || !wr_ok) ? '0 : vd_q + IDX_W'(w);
  assign sif.busy        = !rst && (state inside {LOAD, STREAM, DRAIN});
  assign sif.done        = !rst && (state == DONE);
  assign sif.err         = !rst && (err_q || err_c);
endmodule
